// File: rtl/fifo_dibit_reader.sv
// fifo_dibit_reader: pops single bits from a FIFO and packs them into SYM_W-bit symbols
// Ports:
//   CLK      - clock, all state on rising edge
//   RST      - asynchronous active-low reset
//   fEmpty   - FIFO empty flag
//   fData    - FIFO registered read data, valid the cycle after an accepted read
//   fRdEn    - FIFO read enable (combinational)
//   symReady - downstream accepts the presented symbol
//   symValid - symOut holds a valid symbol
//   symOut   - assembled symbol, first-popped bit in the MSB
// Macro FIFO_DIBIT_READER_PREFETCH_EN: when defined, the next symbol is fetched
// while the current one waits in symOut; otherwise reads pause while a symbol is held.
module fifo_dibit_reader #(
    parameter int SYM_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fEmpty,
    input  logic             fData,
    output logic             fRdEn,
    input  logic             symReady,
    output logic             symValid,
    output logic [SYM_W-1:0] symOut
);
    localparam int CW = $clog2(SYM_W + 1);
    localparam logic [CW-1:0] FULL = CW'(SYM_W);
    localparam logic [CW-1:0] LAST = CW'(SYM_W - 1);

    logic             r_pend;
    logic [CW-1:0]    r_cnt;
    logic [SYM_W-1:0] r_sh;
    logic [SYM_W-1:0] r_sym;
    logic             r_vld;
    logic             w_gate;
    logic             w_free;
    logic             w_done;
    logic             w_held;
    logic [CW-1:0]    w_inflight;
    logic [SYM_W-1:0] w_new;

`ifdef FIFO_DIBIT_READER_PREFETCH_EN
    assign w_gate = 1'b1;
`else
    assign w_gate = !r_vld;
`endif

    // Captured bits plus the read still in flight must never exceed one symbol.
    assign w_inflight = r_cnt + CW'(r_pend);
    assign fRdEn      = RST && !fEmpty && (w_inflight < FULL) && w_gate;
    assign w_new      = {r_sh[SYM_W-2:0], fData};
    assign w_done     = r_pend && (r_cnt == LAST);
    assign w_held     = (r_cnt == FULL);
    assign w_free     = !r_vld || symReady;
    assign symValid   = r_vld;
    assign symOut     = r_sym;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_sh   <= '0;
            r_sym  <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_pend <= fRdEn;
            if (r_pend)
                r_sh <= w_new;
            if (w_done && w_free) begin
                r_sym <= w_new;
                r_vld <= 1'b1;
                r_cnt <= '0;
            end else if (w_held && r_vld && symReady) begin
                // a completed symbol parked in r_sh moves out as the old one leaves
                r_sym <= r_sh;
                r_vld <= 1'b1;
                r_cnt <= '0;
            end else begin
                if (r_pend)
                    r_cnt <= r_cnt + CW'(1);
                if (r_vld && symReady)
                    r_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_dibit_reader.sv
// tb_fifo_dibit_reader: scoreboard bench for fifo_dibit_reader with a bit-FIFO model
module tb_fifo_dibit_reader;
    localparam int SYM_W = 2;
`ifdef FIFO_DIBIT_READER_PREFETCH_EN
    localparam int EXTRA = SYM_W;
`else
    localparam int EXTRA = 0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             fEmpty;
    logic             fData = 1'b0;
    logic             fRdEn;
    logic             symReady = 1'b0;
    logic             symValid;
    logic [SYM_W-1:0] symOut;

    logic             mem [0:4095];
    int               wp = 0;
    int               rp = 0;
    logic [SYM_W-1:0] exp_q [$];
    logic [SYM_W-1:0] part = '0;
    int               pcnt = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    logic             prev_hold = 1'b0;
    logic [SYM_W-1:0] prev_sym = '0;
    logic [SYM_W-1:0] e;

    fifo_dibit_reader #(.SYM_W(SYM_W)) dut (
        .CLK(CLK), .RST(RST), .fEmpty(fEmpty), .fData(fData), .fRdEn(fRdEn),
        .symReady(symReady), .symValid(symValid), .symOut(symOut)
    );

    always #5 CLK = ~CLK;

    // External FIFO: registered read data, one bit per accepted read
    assign fEmpty = (wp == rp);
    always @(posedge CLK) if (fRdEn) begin
        fData <= mem[rp];
        rp    <= rp + 1;
    end

    // Reference: every SYM_W bits written, in order, form one symbol, first bit in MSB
    task automatic push_bit(input logic b);
        mem[wp] = b;
        wp++;
        part = {part[SYM_W-2:0], b};
        pcnt++;
        if (pcnt == SYM_W) begin
            exp_q.push_back(part);
            pcnt = 0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drain(input bit rnd);
        int t = 0;
        while ((exp_q.size() != 0 || symValid) && t < 2000) begin
            symReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        check("drain_timeout", int'(t >= 2000), 0);
        symReady = 1'b1;
    endtask

    // Monitor: compares every accepted symbol and watches the read/hold rules
    always @(negedge CLK) begin
        if (!RST) begin
            prev_hold = 1'b0;
        end else begin
            if (fEmpty) begin
                n_cmp++;
                if (fRdEn) begin
                    n_err++;
                    $display("FAIL rd_when_empty: fRdEn=1 expected 0");
                end
            end
            if (prev_hold) begin
                n_cmp++;
                if (!symValid || symOut !== prev_sym) begin
                    n_err++;
                    $display("FAIL hold: valid=%b sym=%b expected valid=1 sym=%b", symValid, symOut, prev_sym);
                end
            end
            if (symValid && symReady) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_symbol: got %b expected none", symOut);
                end else begin
                    e = exp_q.pop_front();
                    if (symOut !== e) begin
                        n_err++;
                        $display("FAIL symbol: got %b expected %b", symOut, e);
                    end
                end
            end
            prev_hold = symValid && !symReady;
            prev_sym  = symOut;
        end
    end

    initial begin
        int n;
        int rp0;
        logic [15:0] word;
        // reset state with data already waiting in the FIFO
        symReady = 1'b1;
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
        step(); step();
        check("rst_rden", int'(fRdEn), 0);
        check("rst_valid", int'(symValid), 0);
        check("rst_symout", int'(symOut), 0);
        // preloaded 1,0,1,1: first symbol SYM_W+1 cycles after first read
        RST = 1'b1;
        #1;
        n = 0;
        while (!fRdEn && n < 20) begin step(); n++; end
        check("first_rden_seen", int'(fRdEn), 1);
        n = 0;
        while (!symValid && n < 20) begin step(); n++; end
        check("latency", n, SYM_W + 1);
        drain(1'b0);
        // one bit, then the second bit 5 cycles later: exactly two reads
        rp0 = rp;
        push_bit(1'b1);
        repeat (5) step();
        check("gap_rden", int'(fRdEn), 0);
        check("gap_valid", int'(symValid), 0);
        push_bit(1'b0);
        drain(1'b0);
        repeat (3) step();
        check("gap_reads", rp - rp0, 2);
        // back-pressure with 6 bits queued
        symReady = 1'b0;
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
        n = 0;
        while (!symValid && n < 20) begin step(); n++; end
        check("bp_valid", int'(symValid), 1);
        rp0 = rp;
        repeat (10) step();
        check("bp_extra_reads", rp - rp0, EXTRA);
        check("bp_rden", int'(fRdEn), 0);
        check("bp_symout", int'(symOut), 3);
        drain(1'b0);
        // reset after one bit captured: that bit is discarded
        push_bit(1'b1);
        repeat (3) step();
        RST = 1'b0;
        pcnt = 0;
        #1;
        check("mid_rst_valid", int'(symValid), 0);
        check("mid_rst_symout", int'(symOut), 0);
        check("mid_rst_rden", int'(fRdEn), 0);
        step();
        RST = 1'b1;
        push_bit(1'b0); push_bit(1'b1);
        drain(1'b0);
        // 0xA5C3 streamed MSB first under random ready
        word = 16'hA5C3;
        for (int i = 15; i >= 0; i--) push_bit(word[i]);
        drain(1'b1);
        // random bits with random FIFO gaps and random ready
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) push_bit(1'($urandom_range(0, 1)));
            symReady = 1'($urandom_range(0, 1));
            step();
        end
        while (pcnt != 0) push_bit(1'($urandom_range(0, 1)));
        drain(1'b1);
        check("leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
